// File: rtl/upower_fetch_stage.sv
// upower_fetch_stage: instruction-fetch front end for the uPOWER core.
// Issues word-aligned requests to a synchronous instruction memory. Responses
// land in a 2-entry FIFO of {pc, instr} that feeds decode over valid/ready.
// Taken branches from execute flush the FIFO and redirect the fetch PC.
module upower_fetch_stage #(
  parameter int             N        = 64,
  parameter logic [N-1:0]   RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_req,
  output logic [N-1:0]  imem_addr,
  input  logic [31:0]   imem_rdata,
  output logic [31:0]   curr_instr,
  output logic [N-1:0]  curr_pc,
  output logic          instr_valid,
  input  logic          instr_ready,
  input  logic          BranchEqual,
  input  logic          BranchNotEqual,
  input  logic          zero_flag,
  input  logic [N-1:0]  immediate,
  input  logic [N-1:0]  branch_pc
);

  localparam logic [1:0] S_RESET    = 2'd0;
  localparam logic [1:0] S_FETCH    = 2'd1;
  localparam logic [1:0] S_REDIRECT = 2'd2;

  // Control state
  logic [1:0]   r_state;
  logic [N-1:0] r_fetch_pc;
  logic         r_inflight;
  logic         r_kill;
  logic [1:0]   r_count;

  // Datapath state: in-flight PC and the two FIFO entries (entry 0 is the head)
  logic [N-1:0] r_inflight_pc;
  logic [N-1:0] r_pc0;
  logic [N-1:0] r_pc1;
  logic [31:0]  r_ins0;
  logic [31:0]  r_ins1;

  logic         w_active;
  logic         w_taken;
  logic [N-1:0] w_target;
  logic         w_valid;
  logic         w_pop;
  logic         w_push;
  logic [2:0]   w_level;
  logic         w_req;

  // Branch resolution, FIFO handshake and request gating
  always_comb begin
    w_active = (r_state != S_RESET);
    // Both beq and bne asserted always resolves taken: one of the two holds.
    w_taken  = w_active & ((BranchEqual & zero_flag) | (BranchNotEqual & ~zero_flag));
    w_target = branch_pc + (immediate << 2);
    w_valid  = (r_count != 2'd0);
    w_pop    = w_valid & instr_ready;
    // A response arriving in a redirect cycle is stale and is dropped with the flush.
    w_push   = r_inflight & ~r_kill & ~w_taken;
    // Entries the FIFO will hold once this cycle's pop and pending push settle;
    // a new request is only safe if its response will still find room.
    w_level  = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    w_req    = w_active & ~w_taken & (w_level < 3'd2);
  end

  assign imem_req    = w_req;
  assign imem_addr   = r_fetch_pc;
  assign instr_valid = w_valid;
  assign curr_pc     = w_valid ? r_pc0  : '0;
  assign curr_instr  = w_valid ? r_ins0 : '0;

  // FSM, fetch PC, in-flight tracking and FIFO occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_RESET;
      r_fetch_pc <= RESET_PC;
      r_inflight <= 1'b0;
      r_kill     <= 1'b0;
      r_count    <= 2'd0;
    end else begin
      case (r_state)
        S_RESET:    r_state <= S_FETCH;
        S_FETCH:    r_state <= w_taken ? S_REDIRECT : S_FETCH;
        S_REDIRECT: r_state <= w_taken ? S_REDIRECT : S_FETCH;
        default:    r_state <= S_RESET;
      endcase

      if (w_taken) begin
        r_count    <= 2'd0;
        r_fetch_pc <= w_target;
        r_kill     <= r_inflight;
        r_inflight <= 1'b0;
      end else begin
        r_kill     <= 1'b0;
        r_inflight <= w_req;
        if (w_req) begin
          r_fetch_pc <= r_fetch_pc + N'(4);
        end
        r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
    end
  end

  // FIFO storage and in-flight PC; contents are qualified by r_count/r_inflight
  always_ff @(posedge clk) begin
    if (w_req) begin
      r_inflight_pc <= r_fetch_pc;
    end
    if (!w_taken) begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_pc0  <= r_inflight_pc;
            r_ins0 <= imem_rdata;
          end else begin
            r_pc1  <= r_inflight_pc;
            r_ins1 <= imem_rdata;
          end
        end
        2'b01: begin
          r_pc0  <= r_pc1;
          r_ins0 <= r_ins1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_pc0  <= r_inflight_pc;
            r_ins0 <= imem_rdata;
          end else begin
            r_pc0  <= r_pc1;
            r_ins0 <= r_ins1;
            r_pc1  <= r_inflight_pc;
            r_ins1 <= imem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_upower_fetch_stage.sv
// Testbench for upower_fetch_stage: directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against a queue model.
module tb_upower_fetch_stage;

  localparam int N = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          imem_req;
  logic [N-1:0]  imem_addr;
  logic [31:0]   imem_rdata;
  logic [31:0]   curr_instr;
  logic [N-1:0]  curr_pc;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic          BranchEqual = 1'b0;
  logic          BranchNotEqual = 1'b0;
  logic          zero_flag = 1'b0;
  logic [N-1:0]  immediate = '0;
  logic [N-1:0]  branch_pc = '0;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  bit           m_active;
  logic [63:0]  m_fpc;
  bit           m_inf;
  logic [63:0]  m_ipc;
  logic [63:0]  q_pc[$];

  upower_fetch_stage #(.N(N), .RESET_PC('0)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .curr_instr(curr_instr), .curr_pc(curr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .BranchEqual(BranchEqual), .BranchNotEqual(BranchNotEqual),
    .zero_flag(zero_flag), .immediate(immediate), .branch_pc(branch_pc)
  );

  always #5 clk = ~clk;

  // Memory holds word i at byte address 4i
  function automatic logic [31:0] memf(input logic [63:0] a);
    return a[33:2];
  endfunction

  // Synchronous instruction memory: data valid the cycle after the request
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= memf(imem_addr);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_fpc    = 64'd0;
    m_inf    = 1'b0;
    q_pc.delete();
  endtask

  // One clock cycle: drive inputs, compare every output against the model,
  // then advance the model by what the coming edge must do.
  task automatic cycle(input bit rdy, input bit beq, input bit bne, input bit z,
                       input logic [63:0] imm, input logic [63:0] bpc);
    bit taken, pop, req;
    int lvl;
    @(negedge clk);
    instr_ready    = rdy;
    BranchEqual    = beq;
    BranchNotEqual = bne;
    zero_flag      = z;
    immediate      = imm;
    branch_pc      = bpc;
    #1;
    taken = m_active && ((beq && z) || (bne && !z));
    pop   = (q_pc.size() > 0) && rdy;
    lvl   = q_pc.size() + int'(m_inf) - int'(pop);
    req   = m_active && !taken && (lvl < 2);
    chk("req", {63'd0, imem_req}, {63'd0, req});
    if (req) chk("addr", imem_addr, m_fpc);
    chk("valid", {63'd0, instr_valid}, {63'd0, q_pc.size() > 0});
    if (q_pc.size() > 0) begin
      chk("pc", curr_pc, q_pc[0]);
      chk("instr", {32'd0, curr_instr}, {32'd0, memf(q_pc[0])});
    end
    if (!m_active) begin
      m_active = 1'b1;
    end else if (taken) begin
      q_pc.delete();
      m_fpc = bpc + (imm << 2);
      m_inf = 1'b0;
    end else begin
      if (pop) void'(q_pc.pop_front());
      if (m_inf) q_pc.push_back(m_ipc);
      m_inf = req;
      if (req) begin
        m_ipc = m_fpc;
        m_fpc = m_fpc + 64'd4;
      end
    end
  endtask

  // Raise rst between edges, check outputs clear at once, release between edges
  task automatic async_reset();
    @(negedge clk);
    BranchEqual    = 1'b0;
    BranchNotEqual = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_req",   {63'd0, imem_req},    64'd0);
    chk("rst_valid", {63'd0, instr_valid}, 64'd0);
    chk("rst_pc",    curr_pc,              64'd0);
    chk("rst_instr", {32'd0, curr_instr},  64'd0);
    model_reset();
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    logic [63:0] imm, bpc;
    bit br, rdy;

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("init_req",   {63'd0, imem_req},    64'd0);
    chk("init_valid", {63'd0, instr_valid}, 64'd0);
    chk("init_pc",    curr_pc,              64'd0);
    chk("init_instr", {32'd0, curr_instr},  64'd0);
    #1 rst = 1'b0;

    // Sequential fetch with decode always ready
    cycle(1, 0, 0, 0, 0, 0);
    chk("t1_noreq_c0", {63'd0, imem_req}, 64'd0);
    cycle(1, 0, 0, 0, 0, 0);
    chk("t1_req_c1", {63'd0, imem_req}, 64'd1);
    chk("t1_addr_c1", imem_addr, 64'h0);
    cycle(1, 0, 0, 0, 0, 0);
    chk("t1_addr_c2", imem_addr, 64'h4);
    cycle(1, 0, 0, 0, 0, 0);
    chk("t1_valid_c3", {63'd0, instr_valid}, 64'd1);
    chk("t1_pc_c3", curr_pc, 64'h0);
    chk("t1_instr_c3", {32'd0, curr_instr}, 64'd0);
    cycle(1, 0, 0, 0, 0, 0);
    chk("t1_pc_c4", curr_pc, 64'h4);
    chk("t1_instr_c4", {32'd0, curr_instr}, 64'd1);
    cycle(1, 0, 0, 0, 0, 0);
    chk("t1_pc_c5", curr_pc, 64'h8);

    // Backpressure for five cycles
    repeat (5) cycle(0, 0, 0, 0, 0, 0);
    chk("t2_req_stall", {63'd0, imem_req}, 64'd0);
    chk("t2_pc_stall", curr_pc, 64'hC);
    chk("t2_instr_stall", {32'd0, curr_instr}, 64'd3);
    cycle(1, 0, 0, 0, 0, 0);
    chk("t2_resume_req", {63'd0, imem_req}, 64'd1);
    chk("t2_resume_addr", imem_addr, 64'h14);
    cycle(1, 0, 0, 0, 0, 0);
    chk("t2_resume_pc", curr_pc, 64'h10);

    // beq taken: 0x10 + (3<<2) = 0x1C
    cycle(1, 1, 0, 1, 64'd3, 64'h10);
    chk("t3_noreq_redirect", {63'd0, imem_req}, 64'd0);
    cycle(1, 0, 0, 0, 0, 0);
    chk("t3_target_addr", imem_addr, 64'h1C);
    chk("t3_flushed", {63'd0, instr_valid}, 64'd0);
    cycle(1, 0, 0, 0, 0, 0);
    chk("t3_stale_dropped", {63'd0, instr_valid}, 64'd0);
    cycle(1, 0, 0, 0, 0, 0);
    chk("t3_first_pc", curr_pc, 64'h1C);
    chk("t3_first_instr", {32'd0, curr_instr}, 64'd7);

    // bne with zero set: not taken
    cycle(1, 0, 1, 1, 64'd5, 64'h200);
    chk("t4_bne_nt_addr", imem_addr, 64'h28);
    // bne with zero clear, immediate -2: 0x100 - 8 = 0xF8
    cycle(1, 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h100);
    chk("t4_bne_t_noreq", {63'd0, imem_req}, 64'd0);
    cycle(1, 0, 0, 0, 0, 0);
    chk("t4_bne_target", imem_addr, 64'hF8);

    // Wrap: target 0 + (-1<<2) = 2^64-4, then 0
    cycle(1, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
    cycle(1, 0, 0, 0, 0, 0);
    chk("t5_top_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    cycle(1, 0, 0, 0, 0, 0);
    chk("t5_wrap_addr", imem_addr, 64'h0);
    cycle(1, 0, 0, 0, 0, 0);
    chk("t5_top_pc", curr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("t5_top_instr", {32'd0, curr_instr}, 64'hFFFF_FFFF);
    cycle(1, 0, 0, 0, 0, 0);
    chk("t5_wrap_pc", curr_pc, 64'h0);

    // beq and bne together always redirect
    cycle(1, 1, 1, 1'($urandom_range(0, 1)), 64'd1, 64'h40);
    chk("both_noreq", {63'd0, imem_req}, 64'd0);
    cycle(1, 0, 0, 0, 0, 0);
    chk("both_target", imem_addr, 64'h44);

    // Asynchronous reset mid-stream, restart at RESET_PC
    async_reset();
    cycle(1, 0, 0, 0, 0, 0);
    chk("t6_noreq_c0", {63'd0, imem_req}, 64'd0);
    cycle(1, 0, 0, 0, 0, 0);
    chk("t6_restart_addr", imem_addr, 64'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) async_reset();
      r   = $urandom;
      imm = {{52{r[11]}}, r[11:0]};
      bpc = {$urandom, $urandom} & ~64'h3;
      rdy = ($urandom_range(0, 3) != 0);
      br  = ($urandom_range(0, 11) == 0);
      cycle(rdy, br & r[12], br & r[13], r[14], imm, bpc);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
